// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified memory port arbiter.
// Holds the FSM state encoding, load/store width codes and bus lane geometry.
package mem_port_arbiter_pkg;

  localparam int WORD_W = 32;
  localparam int LANES  = WORD_W / 8;

  typedef enum logic [2:0] {
    IDLE,
    D_REQ,
    D_WAIT,
    I_REQ,
    I_WAIT
  } arb_state_t;

  // func3 width/sign codes as driven by the control unit
  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

endpackage

// File: rtl/mem_port_arbiter_lsu_align.sv
// Combinational byte-lane logic: request side builds byte enables, replicated write
// data and the misalign flag; response side shifts and extends load data.
module mem_port_arbiter_lsu_align
  import mem_port_arbiter_pkg::*;
(
  input  logic [2:0]        func3,
  input  logic [1:0]        addr_lo,
  input  logic [WORD_W-1:0] wdata,
  output logic [LANES-1:0]  be,
  output logic [WORD_W-1:0] wdata_lane,
  output logic              misalign,
  input  logic [2:0]        rsp_func3,
  input  logic [1:0]        rsp_addr_lo,
  input  logic [WORD_W-1:0] rdata,
  output logic [WORD_W-1:0] rdata_ext
);

  logic [WORD_W-1:0] shifted;

  always_comb begin
    be         = '1;
    wdata_lane = wdata;
    misalign   = |addr_lo;
    case (func3)
      LS_B, LS_BU: begin
        be         = LANES'(1) << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        misalign   = 1'b0;
      end
      LS_H, LS_HU: begin
        be         = LANES'(3) << addr_lo;
        wdata_lane = {2{wdata[15:0]}};
        misalign   = addr_lo[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted   = rdata >> {rsp_addr_lo, 3'b000};
    rdata_ext = shifted;
    case (rsp_func3)
      LS_B:    rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
      LS_BU:   rdata_ext = {24'b0, shifted[7:0]};
      LS_H:    rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
      LS_HU:   rdata_ext = {16'b0, shifted[15:0]};
      LS_W:    rdata_ext = shifted;
      default: rdata_ext = shifted;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and data access,
// with data-over-fetch priority, one outstanding transaction and bus timeout.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_load,
  input  logic                d_store,
  input  logic [2:0]          d_func3,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                stall,
  output logic                misalign,
  output logic                bus_err,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W/8-1:0] bus_be,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_gnt,
  input  logic                bus_rvalid,
  input  logic [DATA_W-1:0]   bus_rdata,
  output arb_state_t          arb_state
);

  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

  arb_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       func3_q;
  logic [1:0]       addr_lo_q;
  logic             store_q;

  logic              d_any, lsu_mis, granted, responded, to_hit, timeout;
  logic [3:0]        lsu_be;
  logic [DATA_W-1:0] lsu_wdata, lsu_rdata;
  logic              unused_if_lo;

  assign unused_if_lo = ^if_addr[1:0];
  assign d_any        = d_load | d_store;
  assign arb_state    = state;

  mem_port_arbiter_lsu_align u_align (
    .func3       (d_func3),
    .addr_lo     (d_addr[1:0]),
    .wdata       (d_wdata),
    .be          (lsu_be),
    .wdata_lane  (lsu_wdata),
    .misalign    (lsu_mis),
    .rsp_func3   (func3_q),
    .rsp_addr_lo (addr_lo_q),
    .rdata       (bus_rdata),
    .rdata_ext   (lsu_rdata)
  );

  // Bus handshake: bus_req and its payload stay stable until a cycle with bus_gnt;
  // exactly one bus_rvalid (read data or write ack) then completes the transaction.
  assign granted   = ((state == D_REQ) || (state == I_REQ)) && bus_gnt;
  assign responded = ((state == D_WAIT) || (state == I_WAIT)) && bus_rvalid;
  assign to_hit    = (TIMEOUT_CYC != 0) && (cnt == CNT_MAX);
  assign timeout   = (state != IDLE) && to_hit && !granted && !responded;

  always_comb begin
    state_nxt = state;
    misalign  = 1'b0;
    case (state)
      IDLE: begin
        if (d_any) begin
          if (lsu_mis) misalign = 1'b1;
          else         state_nxt = D_REQ;
        end else if (if_req) begin
          state_nxt = I_REQ;
        end
      end
      D_REQ:   if (bus_gnt)    state_nxt = D_WAIT;
      D_WAIT:  if (bus_rvalid) state_nxt = IDLE;
      I_REQ:   if (bus_gnt)    state_nxt = I_WAIT;
      I_WAIT:  if (bus_rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (timeout) state_nxt = IDLE;

    // A timeout completes the waiting requester with zero data so the pipeline unfreezes
    d_rvalid  = ((state == D_WAIT) && bus_rvalid) ||
                (((state == D_REQ) || (state == D_WAIT)) && timeout);
    d_rdata   = ((state == D_WAIT) && bus_rvalid && !store_q) ? lsu_rdata : '0;
    if_rvalid = ((state == I_WAIT) && bus_rvalid) ||
                (((state == I_REQ) || (state == I_WAIT)) && timeout);
    if_rdata  = ((state == I_WAIT) && bus_rvalid) ? bus_rdata : '0;
    stall     = (d_any && !d_rvalid && !misalign) || (if_req && !if_rvalid);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      func3_q   <= '0;
      addr_lo_q <= '0;
      store_q   <= 1'b0;
      bus_err   <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && (state_nxt == D_REQ)) begin
        bus_req   <= 1'b1;
        bus_we    <= d_store;
        bus_addr  <= {d_addr[ADDR_W-1:2], 2'b00};
        bus_be    <= lsu_be;
        bus_wdata <= d_store ? lsu_wdata : '0;
        func3_q   <= d_func3;
        addr_lo_q <= d_addr[1:0];
        store_q   <= d_store;
        cnt       <= '0;
      end else if ((state == IDLE) && (state_nxt == I_REQ)) begin
        bus_req   <= 1'b1;
        bus_we    <= 1'b0;
        bus_addr  <= {if_addr[ADDR_W-1:2], 2'b00};
        bus_be    <= '1;
        bus_wdata <= '0;
        cnt       <= '0;
      end else begin
        if (granted || timeout) begin
          bus_req   <= 1'b0;
          bus_we    <= 1'b0;
          bus_addr  <= '0;
          bus_be    <= '0;
          bus_wdata <= '0;
        end
        if ((state != IDLE) && (cnt != CNT_MAX)) cnt <= cnt + 1'b1;
      end
      if (timeout) bus_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a bus responder, stimulus tasks that push
// expected load/fetch results, and a negedge monitor that pops and compares them.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_load = 1'b0, d_store = 1'b0;
  logic [2:0]  d_func3 = '0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        stall, misalign, bus_err, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt = 1'b0, bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = '0;
  arb_state_t  arb_state;

  logic        resp_en = 1'b1;
  logic [31:0] resp_data = '0;
  logic [31:0] d_exp_q[$];
  logic [31:0] if_exp_q[$];
  int          n_pass = 0;
  int          n_total = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_load(d_load), .d_store(d_store), .d_func3(d_func3), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .stall(stall), .misalign(misalign), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata), .arb_state(arb_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // bus responder: grant the cycle bus_req is seen, return data the next cycle
  always begin
    @(posedge clk);
    #1;
    if (resp_en) begin
      bus_rvalid = 1'b0;
      bus_rdata  = '0;
      if (bus_gnt) begin
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b1;
        bus_rdata  = resp_data;
      end else if (bus_req) begin
        bus_gnt = 1'b1;
      end
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (d_rvalid) begin
      if (d_exp_q.size() == 0) begin
        n_total++;
        $display("FAIL d_unexpected: got d_rvalid rdata 0x%08h expected no response", d_rdata);
      end else check("d_rdata", d_rdata, d_exp_q.pop_front());
    end
    if (if_rvalid) begin
      if (if_exp_q.size() == 0) begin
        n_total++;
        $display("FAIL if_unexpected: got if_rvalid rdata 0x%08h expected no response", if_rdata);
      end else check("if_rdata", if_rdata, if_exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic data_txn(input string name, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                          input logic [31:0] exp_rd, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd, input int exp_lat);
    int n;
    resp_data = rd;
    d_exp_q.push_back(exp_rd);
    @(posedge clk); #1;
    d_load = !st; d_store = st; d_func3 = f3; d_addr = addr; d_wdata = wd;
    n = 0;
    @(negedge clk);
    while (!bus_req && n < 20) begin @(negedge clk); n++; end
    check({name, "_req"}, 32'(bus_req), 32'd1);
    check({name, "_we"}, 32'(bus_we), 32'(st));
    check({name, "_addr"}, bus_addr, addr & 32'hFFFF_FFFC);
    check({name, "_be"}, 32'(bus_be), 32'(exp_be));
    if (st) check({name, "_wdata"}, bus_wdata, exp_wd);
    check({name, "_stall"}, 32'(stall), 32'd1);
    while (!d_rvalid && n < 40) begin @(negedge clk); n++; end
    if (exp_lat >= 0) check({name, "_lat"}, n, exp_lat);
    else check({name, "_done"}, 32'(d_rvalid), 32'd1);
    check({name, "_stall_off"}, 32'(stall), 32'd0);
    @(posedge clk); #1;
    d_load = 1'b0; d_store = 1'b0;
  endtask

  task automatic fetch_txn(input logic [31:0] addr, input logic [31:0] rd);
    int n;
    resp_data = rd;
    if_exp_q.push_back(rd);
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = addr;
    n = 0;
    @(negedge clk);
    while (!bus_req && n < 20) begin @(negedge clk); n++; end
    check("if_addr", bus_addr, addr);
    check("if_we", 32'(bus_we), 32'd0);
    while (!if_rvalid && n < 40) begin @(negedge clk); n++; end
    check("if_lat", n, 2);
    check("if_stall_off", 32'(stall), 32'd0);
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  initial begin
    int n;
    // reset
    repeat (3) @(negedge clk);
    check("rst_state", 32'(arb_state), 32'(IDLE));
    check("rst_bus_ctl", {28'b0, bus_req, bus_we, stall, bus_err}, 32'd0);
    check("rst_bus_be", 32'(bus_be), 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_bus_wdata", bus_wdata, 32'd0);
    check("rst_rsp", {28'b0, d_rvalid, if_rvalid, misalign, 1'b0}, 32'd0);
    check("rst_rdata", d_rdata | if_rdata, 32'd0);
    rst = 1'b0;

    // loads and stores, minimum latency
    data_txn("lw",  1'b0, LS_W,  32'h100, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 4'b1111, 32'h0, 2);
    data_txn("lb",  1'b0, LS_B,  32'h103, 32'h0, 32'h80FFFF00, 32'hFFFFFF80, 4'b1000, 32'h0, 2);
    data_txn("lbu", 1'b0, LS_BU, 32'h103, 32'h0, 32'h80FFFF00, 32'h00000080, 4'b1000, 32'h0, 2);
    data_txn("lh",  1'b0, LS_H,  32'h102, 32'h0, 32'h80010000, 32'hFFFF8001, 4'b1100, 32'h0, 2);
    data_txn("lhu", 1'b0, LS_HU, 32'h102, 32'h0, 32'h80010000, 32'h00008001, 4'b1100, 32'h0, 2);
    data_txn("sh",  1'b1, LS_H,  32'h2,   32'h1234, 32'h0, 32'h0, 4'b1100, 32'h12341234, 2);
    data_txn("sb",  1'b1, LS_B,  32'h1,   32'hFFFFFFAB, 32'h0, 32'h0, 4'b0010, 32'hABABABAB, 2);
    fetch_txn(32'h40, 32'h00000013);

    // data beats fetch when both arrive together
    resp_data = 32'h11112222;
    d_exp_q.push_back(32'h11112222);
    if_exp_q.push_back(32'h00000093);
    @(posedge clk); #1;
    d_load = 1'b1; d_func3 = LS_W; d_addr = 32'h10; if_req = 1'b1; if_addr = 32'h80;
    n = 0;
    @(negedge clk);
    while (!bus_req && n < 20) begin @(negedge clk); n++; end
    check("prio_first_addr", bus_addr, 32'h10);
    while (!d_rvalid && n < 40) begin @(negedge clk); n++; end
    check("prio_d_done", 32'(d_rvalid), 32'd1);
    check("prio_stall_held", 32'(stall), 32'd1);
    resp_data = 32'h00000093;
    @(posedge clk); #1;
    d_load = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus_req && n < 20) begin @(negedge clk); n++; end
    check("prio_second_addr", bus_addr, 32'h80);
    while (!if_rvalid && n < 40) begin @(negedge clk); n++; end
    check("prio_if_done", 32'(if_rvalid), 32'd1);
    @(posedge clk); #1;
    if_req = 1'b0;

    // misaligned word load
    @(posedge clk); #1;
    d_load = 1'b1; d_func3 = LS_W; d_addr = 32'h101;
    @(negedge clk);
    check("mis_pulse", 32'(misalign), 32'd1);
    check("mis_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    d_load = 1'b0;
    @(negedge clk);
    check("mis_no_req", {30'b0, bus_req, misalign}, 32'd0);

    // grant never arrives: timeout
    @(negedge clk);
    resp_en = 1'b0;
    d_exp_q.push_back(32'h0);
    @(posedge clk); #1;
    d_load = 1'b1; d_func3 = LS_W; d_addr = 32'h200;
    n = 0;
    @(negedge clk);
    while (!d_rvalid && n < 40) begin @(negedge clk); n++; end
    check("to_done", 32'(d_rvalid), 32'd1);
    @(posedge clk); #1;
    d_load = 1'b0;
    @(negedge clk);
    check("to_bus_err", 32'(bus_err), 32'd1);
    check("to_idle", {28'b0, bus_req, arb_state}, {28'b0, 1'b0, IDLE});

    // reset during D_WAIT
    @(posedge clk); #1;
    d_load = 1'b1; d_func3 = LS_W; d_addr = 32'h300;
    n = 0;
    @(negedge clk);
    while (!bus_req && n < 20) begin @(negedge clk); n++; end
    bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    @(negedge clk);
    check("rw_in_wait", 32'(arb_state), 32'(D_WAIT));
    #2;
    rst = 1'b1; d_load = 1'b0;
    #1;
    check("rw_state", 32'(arb_state), 32'(IDLE));
    check("rw_outs", {28'b0, bus_req, bus_err, stall, d_rvalid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    bus_rvalid = 1'b1; bus_rdata = 32'hCAFEF00D;
    @(negedge clk);
    check("stray_rvalid", {30'b0, d_rvalid, if_rvalid}, 32'd0);
    @(posedge clk); #1;
    bus_rvalid = 1'b0; bus_rdata = '0;
    resp_en = 1'b1;

    // normal operation resumes
    data_txn("lw2", 1'b0, LS_W, 32'h104, 32'h0, 32'h0BADF00D, 32'h0BADF00D, 4'b1111, 32'h0, 2);

    repeat (3) @(negedge clk);
    check("d_q_drained", d_exp_q.size(), 32'd0);
    check("if_q_drained", if_exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
